// File: rtl/trap_sequencer_if.sv
// Bundle of all pipeline-side and CSR-file-side signals of the trap sequencer.
//   master : the sequencer itself. It receives pipeline requests and CSR read data,
//            and drives the CSR file port, the stall and the redirect.
//   slave  : the surrounding pipeline / CSR file (or a testbench standing in for them).
interface trap_sequencer_if;
  // pipeline Zicsr access
  logic        csr_instr_valid;
  logic [11:0] csr_instr_addr;
  logic [31:0] csr_instr_wdata;
  logic [1:0]  csr_instr_mode;
  logic [31:0] csr_instr_rdata;
  // trap / return requests
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;
  logic        mret_valid;
  // CSR file port
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [31:0] csr_mstatus;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_w;
  logic [1:0]  csr_wsc_mode;
  // pipeline control
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    input  csr_instr_valid, csr_instr_addr, csr_instr_wdata, csr_instr_mode,
    output csr_instr_rdata,
    input  trap_valid, trap_pc, trap_cause, trap_tval, mret_valid,
    output csr_raddr,
    input  csr_rdata, csr_mstatus,
    output csr_waddr, csr_wdata, csr_w, csr_wsc_mode,
    output stall, redirect_valid, redirect_pc
  );

  modport slave (
    output csr_instr_valid, csr_instr_addr, csr_instr_wdata, csr_instr_mode,
    input  csr_instr_rdata,
    output trap_valid, trap_pc, trap_cause, trap_tval, mret_valid,
    input  csr_raddr,
    output csr_rdata, csr_mstatus,
    input  csr_waddr, csr_wdata, csr_w, csr_wsc_mode,
    input  stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap / MRET sequencer in front of the CSR register file.
// Owns the CSR file's single read/write port. In IDLE it passes pipeline Zicsr
// accesses straight through; on a trap it writes mepc, mcause, mtval and mstatus
// on four consecutive cycles and then redirects fetch to mtvec; on MRET it rewrites
// mstatus and then redirects fetch to mepc.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : trap_sequencer_if.master (pipeline requests, CSR file port, stall, redirect)
module trap_sequencer #(
  parameter logic [11:0] MSTATUS_ADDR = 12'h300,
  parameter logic [11:0] MTVEC_ADDR   = 12'h305,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
  parameter logic [11:0] MTVAL_ADDR   = 12'h343
) (
  input  logic               clk,
  input  logic               rst,
  trap_sequencer_if.master   bus
);

  localparam logic [1:0] MODE_WRITE = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_TVAL,
    T_STAT,
    T_JUMP,
    R_STAT,
    R_JUMP
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] cause_q;
  logic [31:0] tval_q;

  // Trap entry: MPIE <- MIE, MIE <- 0.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    return (m & ~32'h0000_0088) | {24'h0, m[3], 7'h0};
  endfunction

  // MRET: MIE <- MPIE, MPIE <- 1.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    return (m & ~32'h0000_0008) | {28'h0, m[7], 3'h0} | 32'h0000_0080;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.trap_valid) begin
            pc_q    <= bus.trap_pc;
            cause_q <= bus.trap_cause;
            tval_q  <= bus.trap_tval;
            state   <= T_EPC;
          end else if (bus.mret_valid) begin
            state <= R_STAT;
          end
        end
        T_EPC:   state <= T_CAUSE;
        T_CAUSE: state <= T_TVAL;
        T_TVAL:  state <= T_STAT;
        T_STAT:  state <= T_JUMP;
        T_JUMP:  state <= IDLE;
        R_STAT:  state <= R_JUMP;
        R_JUMP:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Port steering. Only IDLE depends on live inputs; busy states ignore every request.
  always_comb begin
    bus.csr_raddr       = '0;
    bus.csr_instr_rdata = '0;
    bus.csr_waddr       = '0;
    bus.csr_wdata       = '0;
    bus.csr_w           = 1'b0;
    bus.csr_wsc_mode    = '0;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    case (state)
      IDLE: begin
        bus.csr_raddr       = bus.csr_instr_addr;
        bus.csr_instr_rdata = bus.csr_rdata;
        bus.csr_waddr       = bus.csr_instr_addr;
        bus.csr_wdata       = bus.csr_instr_wdata;
        bus.csr_wsc_mode    = bus.csr_instr_mode;
        // A trap or MRET accepted this cycle wins over the instruction's write.
        bus.csr_w           = bus.csr_instr_valid & ~bus.trap_valid & ~bus.mret_valid;
        bus.stall           = bus.trap_valid | bus.mret_valid;
      end
      T_EPC: begin
        bus.csr_waddr    = MEPC_ADDR;
        bus.csr_wdata    = pc_q;
        bus.csr_w        = 1'b1;
        bus.csr_wsc_mode = MODE_WRITE;
        bus.stall        = 1'b1;
      end
      T_CAUSE: begin
        bus.csr_waddr    = MCAUSE_ADDR;
        bus.csr_wdata    = cause_q;
        bus.csr_w        = 1'b1;
        bus.csr_wsc_mode = MODE_WRITE;
        bus.stall        = 1'b1;
      end
      T_TVAL: begin
        bus.csr_waddr    = MTVAL_ADDR;
        bus.csr_wdata    = tval_q;
        bus.csr_w        = 1'b1;
        bus.csr_wsc_mode = MODE_WRITE;
        bus.stall        = 1'b1;
      end
      T_STAT: begin
        bus.csr_waddr    = MSTATUS_ADDR;
        bus.csr_wdata    = trap_mstatus(bus.csr_mstatus);
        bus.csr_w        = 1'b1;
        bus.csr_wsc_mode = MODE_WRITE;
        bus.stall        = 1'b1;
      end
      T_JUMP: begin
        // Vectored-mode bits of mtvec are dropped; always jump to the base.
        bus.csr_raddr      = MTVEC_ADDR;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = {bus.csr_rdata[31:2], 2'b00};
      end
      R_STAT: begin
        bus.csr_waddr    = MSTATUS_ADDR;
        bus.csr_wdata    = mret_mstatus(bus.csr_mstatus);
        bus.csr_w        = 1'b1;
        bus.csr_wsc_mode = MODE_WRITE;
        bus.stall        = 1'b1;
      end
      R_JUMP: begin
        bus.csr_raddr      = MEPC_ADDR;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = bus.csr_rdata;
      end
      default: begin
        bus.csr_w = 1'b0;
      end
    endcase
  end

endmodule
